// File: rtl/tree_ser_pkg.sv
// Shared types and helpers for the tree-link word serializer.
// State encoding and the word-width rule derived from deserializer tree depth.
package tree_ser_pkg;

    typedef enum logic [1:0] {IDLE, MARK, SHIFT} ser_state_t;

    function automatic int width_f(input int stages);
        return 1 << stages;
    endfunction

endpackage

// File: rtl/tree_ser_tx_if.sv
// Parallel word handshake feeding the serializer.
// The source drives data/valid and the serializer returns ready.
interface tree_ser_tx_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (output in_data, output in_valid, input  in_ready);
    modport slave  (input  in_data, input  in_valid, output in_ready);
endinterface

// File: rtl/ser_skid_fifo.sv
// Two-entry register FIFO that buffers words ahead of the serializer.
// Latency: a pushed word is visible on rdata the cycle after the push.
// Backpressure: a push is refused while full, even in a cycle that also pops.
module ser_skid_fifo #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= !wr_ptr;
            if (do_pop)  rd_ptr <= !rd_ptr;
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/tree_ser_tx.sv
// Serializes buffered words LSB first, with a single '1' marker at the start of each burst.
// Latency: the marker appears on dout 2 edges after en is sampled with a word buffered.
// Backpressure: in_ready = !full; an empty buffer at a frame boundary emits zero frames.
module tree_ser_tx
    import tree_ser_pkg::*;
#(
    parameter int STAGES = 2,
    parameter int DEPTH  = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    tree_ser_tx_if.slave  in_if,
    output logic          dout,
    output logic          busy,
    output logic          underrun
);
    localparam int WIDTH = width_f(STAGES);
    localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    if (DEPTH != 2) begin : g_depth_chk
        $error("tree_ser_tx: DEPTH must be 2");
    end

    ser_state_t       state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             dout_nxt;
    logic             underrun_nxt;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_rdata;

    assign in_if.in_ready = !fifo_full && !rst;
    assign fifo_push      = in_if.in_valid && in_if.in_ready;
    assign busy           = (state != IDLE);

    ser_skid_fifo #(.WIDTH(WIDTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (in_if.in_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_nxt    = state;
        shreg_nxt    = shreg;
        cnt_nxt      = cnt;
        dout_nxt     = 1'b0;
        underrun_nxt = underrun;
        fifo_pop     = 1'b0;
        unique case (state)
            IDLE: begin
                if (en && !fifo_empty) state_nxt = MARK;
            end
            MARK: begin
                dout_nxt  = 1'b1;
                fifo_pop  = 1'b1;
                shreg_nxt = fifo_rdata;
                cnt_nxt   = '0;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                dout_nxt = shreg[cnt];
                cnt_nxt  = cnt + 1'b1;
                if (cnt == CNT_LAST) begin
                    cnt_nxt = '0;
                    // Frame boundary: stop cleanly, chain the next word, or pad with zeros
                    // so the receiver's alignment survives a starved buffer.
                    if (!en) begin
                        state_nxt = IDLE;
                    end else if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        shreg_nxt = fifo_rdata;
                    end else begin
                        shreg_nxt    = '0;
                        underrun_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            cnt      <= '0;
            dout     <= 1'b0;
            underrun <= 1'b0;
        end else begin
            state    <= state_nxt;
            shreg    <= shreg_nxt;
            cnt      <= cnt_nxt;
            dout     <= dout_nxt;
            underrun <= underrun_nxt;
        end
    end

endmodule
